mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter: TIMEOUT, 16, max BUSY cycles without mem_ack before abort (range 2..255).
REQ-002 The block SHALL use one clock and a reset that is synchronous and active-low.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst_n  in  1  synchronous active-low reset.
REQ-005 ex_valid  in  1  EX stage presents an instruction.
REQ-006 ex_alu_result  in  32  ALU result; memory byte address for loads/stores.
REQ-007 ex_store_data  in  32  forwarded rt value (store data).
REQ-008 ex_reg_dest  in  5  destination register number.
REQ-009 ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg  in  1 each  control bits.
REQ-010 flush  in  1  load a bubble into EX/MEM instead of the EX instruction.
REQ-011 mem_req  out  1;  mem_we  out  1;  mem_addr  out  32;  mem_wdata  out  32: data-memory request bus.
REQ-012 mem_rdata  in  32;  mem_ack  in  1: memory response.
REQ-013 stall  out  1  freezes EX and upstream stages.
REQ-014 exmem_alu_result  out  32;  exmem_reg_dest  out  5;  exmem_reg_write  out  1: EX/MEM contents for forwarding.
REQ-015 wb_valid, wb_reg_write  out  1;  wb_reg_dest  out  5;  wb_data  out  32: MEM/WB register.
REQ-016 misaligned, bus_error  out  1  one-cycle fault pulses.

Function
REQ-017 The EX/MEM register SHALL capture the ex_* inputs on every edge where stall=0; with flush=1 it SHALL instead capture a bubble (valid=0, all controls 0).
REQ-018 While stall=1, EX/MEM SHALL hold its contents, and flush and ex_* SHALL be ignored.
REQ-019 The FSM SHALL have states IDLE and BUSY; it enters BUSY on an edge capturing a valid, word-aligned (addr[1:0]=0) instruction with mem_read or mem_write set, and otherwise enters IDLE.
REQ-020 In BUSY: mem_req=1, mem_we=mem_write, mem_addr=EX/MEM address, mem_wdata=EX/MEM store data, all stable until exit; in IDLE: mem_req=0, mem_we=0.
REQ-021 stall SHALL be combinational: stall = (state==BUSY) && !mem_ack && !timeout_hit.
REQ-022 A wait counter SHALL clear on BUSY entry and increment each BUSY cycle without ack; timeout_hit = (count == TIMEOUT-1) && !mem_ack.
REQ-023 On an edge with state BUSY and mem_ack=1, MEM/WB SHALL capture: wb_valid=1; wb_reg_write=EX/MEM reg_write; wb_data=mem_rdata if mem_to_reg else alu_result; and the FSM SHALL re-evaluate REQ-019 against the newly captured instruction.
REQ-024 On a timeout_hit edge, the block SHALL write a bubble to MEM/WB (wb_valid=0, wb_reg_write=0), pulse bus_error for one cycle, and return to IDLE.
REQ-025 A valid misaligned memory op SHALL issue no request, SHALL advance to MEM/WB as a bubble one edge later, and SHALL pulse misaligned in the cycle that MEM/WB holds it.
REQ-026 Non-memory instructions SHALL advance EX/MEM to MEM/WB in one edge, with wb_data=alu_result.
REQ-027 Latency: with zero-wait memory (ack in the first BUSY cycle), a load or store SHALL add no stall cycle; each wait cycle SHALL add exactly one stall cycle.
REQ-028 A store SHALL reach MEM/WB with wb_reg_write=0 regardless of the ex_reg_write bit.
REQ-029 exmem_* outputs SHALL reflect EX/MEM contents directly (registered, no combinational path from ex_*).

Reset
REQ-030 On an edge with rst_n=0, all EX/MEM and MEM/WB fields, the counter, misaligned and bus_error SHALL clear to 0 and the state SHALL become IDLE; in the following cycle mem_req=0 and stall=0, including when reset occurs in BUSY (the outstanding access is abandoned; a late mem_ack is ignored).

Verification
REQ-031 ALU op (alu_result=0x00000010, reg_dest=5, reg_write=1) -> one edge later wb_valid=1, wb_reg_dest=5, wb_data=0x10; stall=0 throughout.
REQ-032 Load at 0x100, memory acks after 3 wait cycles with rdata=0xDEADBEEF -> mem_req high 4 cycles, stall high 3 cycles, then wb_data=0xDEADBEEF.
REQ-033 Store at 0x204 with data 0x12345678, ack in first cycle -> mem_we=1 and mem_wdata=0x12345678 for 1 cycle, no stall, wb_reg_write=0.
REQ-034 Load at 0x102 -> mem_req stays 0, misaligned pulses once, wb_valid=0.
REQ-035 Load with mem_ack never asserted, TIMEOUT=16 -> stall high 15 cycles, bus_error pulses once, wb_valid=0, state IDLE.
REQ-036 rst_n low during a BUSY wait, then release -> mem_req=0, all wb_* outputs 0, and a subsequent ALU op completes normally.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - data-memory request/response bus between the memory access unit and data memory
//
// Signals:
//   mem_req   request active (held for the whole access)
//   mem_we    1 = write, 0 = read
//   mem_addr  byte address (word aligned)
//   mem_wdata store data
//   mem_rdata load data, valid with mem_ack
//   mem_ack   access complete
// Modports: master = memory access unit, slave = data memory.
interface mem_access_unit_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - pipeline MEM stage: EX/MEM and MEM/WB registers with a data-memory access FSM
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   ex_*                       instruction presented by the EX stage
//   flush                      capture a bubble into EX/MEM instead of the EX instruction
//   bus                        data-memory request/response bus (master side)
//   stall                      freezes EX and upstream stages while an access waits
//   exmem_*                    registered EX/MEM fields for forwarding
//   wb_*                       MEM/WB register
//   misaligned, bus_error      one-cycle fault pulses
module mem_access_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ex_valid,
    input  logic [31:0]               ex_alu_result,
    input  logic [31:0]               ex_store_data,
    input  logic [4:0]                ex_reg_dest,
    input  logic                      ex_mem_read,
    input  logic                      ex_mem_write,
    input  logic                      ex_reg_write,
    input  logic                      ex_mem_to_reg,
    input  logic                      flush,
    mem_access_unit_if.master         bus,
    output logic                      stall,
    output logic [31:0]               exmem_alu_result,
    output logic [4:0]                exmem_reg_dest,
    output logic                      exmem_reg_write,
    output logic                      wb_valid,
    output logic                      wb_reg_write,
    output logic [4:0]                wb_reg_dest,
    output logic [31:0]               wb_data,
    output logic                      misaligned,
    output logic                      bus_error
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t      state, state_next;
    logic        exmem_valid;
    logic [31:0] exmem_store_data;
    logic        exmem_mem_read;
    logic        exmem_mem_write;
    logic        exmem_mem_to_reg;
    logic [7:0]  wait_count;
    logic        timeout_hit;
    logic        exmem_is_mem;

    assign exmem_is_mem = exmem_mem_read || exmem_mem_write;
    assign timeout_hit  = (state == BUSY) && (wait_count == 8'(TIMEOUT - 1)) && !bus.mem_ack;

    // Address and data come straight from EX/MEM, which is frozen while BUSY.
    assign bus.mem_addr  = exmem_alu_result;
    assign bus.mem_wdata = exmem_store_data;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Every non-stalled edge loads a new EX/MEM entry, so the FSM decides
    // from the instruction being captured on that same edge.
    always_comb begin
        state_next = state;
        if (!stall) begin
            if (!flush && ex_valid && (ex_mem_read || ex_mem_write) && (ex_alu_result[1:0] == 2'b00)) begin
                state_next = BUSY;
            end else begin
                state_next = IDLE;
            end
        end
    end

    always_comb begin
        bus.mem_req = (state == BUSY);
        bus.mem_we  = (state == BUSY) && exmem_mem_write;
        stall       = (state == BUSY) && !bus.mem_ack && !timeout_hit;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            exmem_valid      <= 1'b0;
            exmem_alu_result <= '0;
            exmem_store_data <= '0;
            exmem_reg_dest   <= '0;
            exmem_mem_read   <= 1'b0;
            exmem_mem_write  <= 1'b0;
            exmem_reg_write  <= 1'b0;
            exmem_mem_to_reg <= 1'b0;
            wb_valid         <= 1'b0;
            wb_reg_write     <= 1'b0;
            wb_reg_dest      <= '0;
            wb_data          <= '0;
            wait_count       <= '0;
            misaligned       <= 1'b0;
            bus_error        <= 1'b0;
        end else begin
            misaligned <= 1'b0;
            bus_error  <= 1'b0;

            if (!stall) begin
                if (flush) begin
                    exmem_valid      <= 1'b0;
                    exmem_alu_result <= '0;
                    exmem_store_data <= '0;
                    exmem_reg_dest   <= '0;
                    exmem_mem_read   <= 1'b0;
                    exmem_mem_write  <= 1'b0;
                    exmem_reg_write  <= 1'b0;
                    exmem_mem_to_reg <= 1'b0;
                end else begin
                    exmem_valid      <= ex_valid;
                    exmem_alu_result <= ex_alu_result;
                    exmem_store_data <= ex_store_data;
                    exmem_reg_dest   <= ex_reg_dest;
                    exmem_mem_read   <= ex_mem_read;
                    exmem_mem_write  <= ex_mem_write;
                    exmem_reg_write  <= ex_reg_write;
                    exmem_mem_to_reg <= ex_mem_to_reg;
                end
            end

            // Counter restarts on every edge that ends or begins an access.
            if (!stall) begin
                wait_count <= '0;
            end else begin
                wait_count <= wait_count + 8'd1;
            end

            wb_reg_dest <= exmem_reg_dest;
            if (state == IDLE) begin
                // In IDLE a valid memory op can only be a misaligned one.
                wb_valid     <= exmem_valid && !exmem_is_mem;
                wb_reg_write <= exmem_valid && !exmem_is_mem && exmem_reg_write;
                wb_data      <= exmem_alu_result;
                misaligned   <= exmem_valid && exmem_is_mem && (exmem_alu_result[1:0] != 2'b00);
            end else if (bus.mem_ack) begin
                wb_valid     <= 1'b1;
                wb_reg_write <= exmem_reg_write && !exmem_mem_write;
                wb_data      <= exmem_mem_to_reg ? bus.mem_rdata : exmem_alu_result;
            end else begin
                // Waiting or abandoned access: MEM/WB carries a bubble.
                wb_valid     <= 1'b0;
                wb_reg_write <= 1'b0;
                wb_data      <= '0;
                bus_error    <= timeout_hit;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid;
    logic [31:0] ex_alu_result;
    logic [31:0] ex_store_data;
    logic [4:0]  ex_reg_dest;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        ex_reg_write;
    logic        ex_mem_to_reg;
    logic        flush;
    logic        stall;
    logic [31:0] exmem_alu_result;
    logic [4:0]  exmem_reg_dest;
    logic        exmem_reg_write;
    logic        wb_valid;
    logic        wb_reg_write;
    logic [4:0]  wb_reg_dest;
    logic [31:0] wb_data;
    logic        misaligned;
    logic        bus_error;

    int errors = 0;
    int checks = 0;
    int req_cnt;
    int stall_cnt;

    mem_access_unit_if bus ();

    mem_access_unit #(.TIMEOUT(16)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .ex_valid         (ex_valid),
        .ex_alu_result    (ex_alu_result),
        .ex_store_data    (ex_store_data),
        .ex_reg_dest      (ex_reg_dest),
        .ex_mem_read      (ex_mem_read),
        .ex_mem_write     (ex_mem_write),
        .ex_reg_write     (ex_reg_write),
        .ex_mem_to_reg    (ex_mem_to_reg),
        .flush            (flush),
        .bus              (bus),
        .stall            (stall),
        .exmem_alu_result (exmem_alu_result),
        .exmem_reg_dest   (exmem_reg_dest),
        .exmem_reg_write  (exmem_reg_write),
        .wb_valid         (wb_valid),
        .wb_reg_write     (wb_reg_write),
        .wb_reg_dest      (wb_reg_dest),
        .wb_data          (wb_data),
        .misaligned       (misaligned),
        .bus_error        (bus_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [31:0] addr, input logic [31:0] sdata, input logic [4:0] dest,
                           input logic rd, input logic wr, input logic rw, input logic m2r);
        ex_valid      = 1'b1;
        ex_alu_result = addr;
        ex_store_data = sdata;
        ex_reg_dest   = dest;
        ex_mem_read   = rd;
        ex_mem_write  = wr;
        ex_reg_write  = rw;
        ex_mem_to_reg = m2r;
    endtask

    task automatic idle_ex();
        ex_valid      = 1'b0;
        ex_mem_read   = 1'b0;
        ex_mem_write  = 1'b0;
        ex_reg_write  = 1'b0;
        ex_mem_to_reg = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        ex_alu_result = '0;
        ex_store_data = '0;
        ex_reg_dest   = '0;
        idle_ex();
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        tick();
        tick();
        check("rst_stall", stall, 0);
        check("rst_req", bus.mem_req, 0);
        check("rst_wb_valid", wb_valid, 0);
        check("rst_wb_data", wb_data, 0);
        check("rst_exmem_dest", exmem_reg_dest, 0);
        check("rst_faults", {misaligned, bus_error}, 0);
        rst_n = 1'b1;

        // ALU op
        present(32'h10, 32'h0, 5'd5, 0, 0, 1, 0);
        #1 check("alu_stall0", stall, 0);
        tick();
        check("alu_exmem_res", exmem_alu_result, 32'h10);
        check("alu_exmem_dest", exmem_reg_dest, 5);
        check("alu_exmem_rw", exmem_reg_write, 1);
        check("alu_req", bus.mem_req, 0);
        check("alu_stall1", stall, 0);
        idle_ex();
        tick();
        check("alu_wb_valid", wb_valid, 1);
        check("alu_wb_dest", wb_reg_dest, 5);
        check("alu_wb_data", wb_data, 32'h10);
        check("alu_wb_rw", wb_reg_write, 1);

        // Flush loads a bubble
        present(32'h77, 32'h0, 5'd9, 0, 0, 1, 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        idle_ex();
        check("flush_rw", exmem_reg_write, 0);
        check("flush_res", exmem_alu_result, 0);
        tick();
        check("flush_wb_valid", wb_valid, 0);

        // Load at 0x100, three wait cycles
        present(32'h100, 32'h0, 5'd7, 1, 0, 1, 1);
        tick();
        idle_ex();
        ex_alu_result = 32'h999;
        req_cnt = 0;
        stall_cnt = 0;
        for (int n = 0; n < 4; n++) begin
            bus.mem_ack   = (n == 3);
            bus.mem_rdata = 32'hDEADBEEF;
            #1;
            req_cnt += int'(bus.mem_req);
            stall_cnt += int'(stall);
            if (n == 0) check("ld_addr", bus.mem_addr, 32'h100);
            if (n == 2) check("ld_hold", exmem_alu_result, 32'h100);
            tick();
        end
        bus.mem_ack = 1'b0;
        #1;
        check("ld_req_cycles", req_cnt, 4);
        check("ld_stall_cycles", stall_cnt, 3);
        check("ld_wb_valid", wb_valid, 1);
        check("ld_wb_data", wb_data, 32'hDEADBEEF);
        check("ld_wb_dest", wb_reg_dest, 7);
        check("ld_wb_rw", wb_reg_write, 1);
        check("ld_req_after", bus.mem_req, 0);

        // Store at 0x204, zero wait
        present(32'h204, 32'h12345678, 5'd4, 0, 1, 1, 0);
        tick();
        idle_ex();
        bus.mem_ack = 1'b1;
        #1;
        check("st_req", bus.mem_req, 1);
        check("st_we", bus.mem_we, 1);
        check("st_wdata", bus.mem_wdata, 32'h12345678);
        check("st_stall", stall, 0);
        tick();
        bus.mem_ack = 1'b0;
        #1;
        check("st_req_after", {bus.mem_req, bus.mem_we}, 0);
        check("st_wb_valid", wb_valid, 1);
        check("st_wb_rw", wb_reg_write, 0);
        check("st_wb_data", wb_data, 32'h204);

        // Misaligned load at 0x102
        present(32'h102, 32'h0, 5'd6, 1, 0, 1, 1);
        tick();
        idle_ex();
        check("mis_req0", bus.mem_req, 0);
        check("mis_pulse0", misaligned, 0);
        tick();
        check("mis_pulse1", misaligned, 1);
        check("mis_wb_valid", wb_valid, 0);
        check("mis_req1", bus.mem_req, 0);
        tick();
        check("mis_pulse2", misaligned, 0);

        // Timeout: load never acknowledged
        present(32'h300, 32'h0, 5'd8, 1, 0, 1, 1);
        tick();
        idle_ex();
        req_cnt = 0;
        stall_cnt = 0;
        for (int n = 0; n < 16; n++) begin
            req_cnt += int'(bus.mem_req);
            stall_cnt += int'(stall);
            tick();
        end
        check("to_req_cycles", req_cnt, 16);
        check("to_stall_cycles", stall_cnt, 15);
        check("to_bus_error", bus_error, 1);
        check("to_wb_valid", wb_valid, 0);
        check("to_idle", bus.mem_req, 0);
        check("to_stall_after", stall, 0);
        tick();
        check("to_bus_error_end", bus_error, 0);

        // Reset in the middle of a wait
        present(32'h400, 32'h0, 5'd2, 1, 0, 1, 1);
        tick();
        idle_ex();
        tick();
        tick();
        check("rb_stall", stall, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        bus.mem_ack = 1'b1;
        #1;
        check("rb_req", bus.mem_req, 0);
        check("rb_stall_after", stall, 0);
        check("rb_wb", {wb_valid, wb_reg_write, 1'b0, wb_reg_dest}, 0);
        check("rb_wb_data", wb_data, 0);
        tick();
        bus.mem_ack = 1'b0;
        check("rb_late_ack", wb_valid, 0);
        present(32'h55, 32'h0, 5'd3, 0, 0, 1, 0);
        tick();
        idle_ex();
        tick();
        check("rb_alu_valid", wb_valid, 1);
        check("rb_alu_data", wb_data, 32'h55);
        check("rb_alu_dest", wb_reg_dest, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
